// File: rtl/nes_poll_scheduler.sv
// ---------------------------------------------------------------------------
// nes_poll_scheduler
//
// Purpose
//   Polls two NES controllers that share one latch line and one serial clock.
//   A poll is a LATCH_CYC-cycle latch pulse followed by 7 sclk pulses. Each
//   pulse is HALF_CYC cycles high and HALF_CYC cycles low. The eight serial
//   bits per port are collected in a shift register. They are published
//   inverted (pressed = 1) on buttons0/buttons1 in a single DONE cycle,
//   together with a one-cycle valid strobe.
//   Polls start from a free-running timer (POLL_HZ, while enable=1) or from
//   a manual start pulse.
//
// Parameters
//   CLK_FREQ  system clock in Hz
//   POLL_HZ   automatic poll rate in Hz
//   LATCH_US  latch width in microseconds (sclk half-period = LATCH_US/2)
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous, active-low reset
//   enable              1 = periodic polling timer runs, 0 = timer held at 0
//   start               one-cycle manual poll request
//   sdata0/sdata1       serial data from controller ports 0/1 (low = pressed)
//   latch               shared latch to both controllers
//   sclk                shared serial clock to both controllers
//   state[1:0]          FSM state: IDLE=00, LATCH=01, CAPTURE=11, DONE=10
//   buttons0/buttons1   pressed = 1; bit7=A,6=B,5=SELECT,4=START,
//                       3=UP,2=DOWN,1=LEFT,0=RIGHT
//   valid               one-cycle pulse when buttons0/1 update
//   busy                1 whenever state != IDLE
//   press0/press1       only with NES_PRESS_EVENT_EN defined. They carry
//                       new & ~old buttons during the valid cycle and are
//                       0 at all other times.
//
// Handshake
//   start and the internal timer tick are fire-and-forget requests with no
//   ready. A request that arrives while a poll is in progress sets a single
//   pending flag, so any number of requests folds into one follow-up poll.
//   valid is a one-cycle strobe with no backpressure. buttons0/1 only change
//   in that cycle.
//
// Configuration macro: NES_PRESS_EVENT_EN (adds press0/press1 outputs)
// ---------------------------------------------------------------------------
module nes_poll_scheduler #(
  parameter int CLK_FREQ = 12000000,
  parameter int POLL_HZ  = 60,
  parameter int LATCH_US = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  input  logic       sdata0,
  input  logic       sdata1,
  output logic       latch,
  output logic       sclk,
  output logic [1:0] state,
  output logic [7:0] buttons0,
  output logic [7:0] buttons1,
  output logic       valid,
  output logic       busy
`ifdef NES_PRESS_EVENT_EN
  ,
  output logic [7:0] press0,
  output logic [7:0] press1
`endif
);

  localparam int LATCH_CYC = (CLK_FREQ / 1000000) * LATCH_US;
  localparam int HALF_CYC  = LATCH_CYC / 2;
  localparam int POLL_CYC  = CLK_FREQ / POLL_HZ;

  // A single counter times both the latch pulse and each sclk period.
  // 2*HALF_CYC never exceeds LATCH_CYC, so one width covers both uses.
  localparam int CNT_W = $clog2(LATCH_CYC + 1);
  localparam int TMR_W = $clog2(POLL_CYC + 1);

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYC - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(2 * HALF_CYC - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_CYC - 1);
  localparam logic [2:0]       LAST_PULSE = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_LATCH   = 2'b01,
    ST_CAPTURE = 2'b11,
    ST_DONE    = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pulse_q, pulse_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             pending_q, pending_d;
  logic [7:0]       sh0_q, sh0_d;
  logic [7:0]       sh1_q, sh1_d;
  logic [7:0]       buttons0_q, buttons0_d;
  logic [7:0]       buttons1_q, buttons1_d;
  logic             valid_q, valid_d;
`ifdef NES_PRESS_EVENT_EN
  logic [7:0]       press0_q, press0_d;
  logic [7:0]       press1_q, press1_d;
`endif

  logic tick;
  logic poll_req;

  // -------------------------------------------------------------------------
  // Poll timer: wraps every POLL_CYC cycles while enabled and ticks on the
  // wrap cycle. Dropping enable parks it at 0, so re-enabling always gives
  // a full period before the first tick.
  // -------------------------------------------------------------------------
  always_comb begin
    tick = enable && (tmr_q == TMR_LAST);
    if (!enable || tick) begin
      tmr_d = '0;
    end else begin
      tmr_d = tmr_q + TMR_W'(1);
    end
  end

  assign poll_req = start | tick;

  // -------------------------------------------------------------------------
  // Poll FSM: next state, counters, sampling and output loads
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pulse_d    = pulse_q;
    pending_d  = pending_q;
    sh0_d      = sh0_q;
    sh1_d      = sh1_q;
    buttons0_d = buttons0_q;
    buttons1_d = buttons1_q;
    valid_d    = 1'b0;
`ifdef NES_PRESS_EVENT_EN
    press0_d   = 8'h00;
    press1_d   = 8'h00;
`endif

    // A request that arrives while busy is remembered as one follow-up poll.
    if ((state_q != ST_IDLE) && poll_req) begin
      pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // start and tick in the same cycle fall into this one branch and
        // produce a single poll. Nothing is left pending.
        if (poll_req || pending_q) begin
          state_d   = ST_LATCH;
          cnt_d     = '0;
          pending_d = 1'b0;
        end
      end

      ST_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          // Button A is on the data line while latch is still high.
          sh0_d   = {sh0_q[6:0], sdata0};
          sh1_d   = {sh1_q[6:0], sdata1};
          cnt_d   = '0;
          pulse_d = '0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_CAPTURE: begin
        // Sample on the last high cycle. The controller shifted on the
        // rising edge, so the data has had the whole high phase to settle.
        if (cnt_q == HALF_LAST) begin
          sh0_d = {sh0_q[6:0], sdata0};
          sh1_d = {sh1_q[6:0], sdata1};
        end
        if (cnt_q == PULSE_LAST) begin
          cnt_d = '0;
          if (pulse_q == LAST_PULSE) begin
            // All 8 bits have been in the shift register since the last
            // high phase. Publish them in one step so no partial value
            // ever appears on the outputs.
            state_d    = ST_DONE;
            buttons0_d = ~sh0_q;
            buttons1_d = ~sh1_q;
            valid_d    = 1'b1;
`ifdef NES_PRESS_EVENT_EN
            press0_d   = ~sh0_q & ~buttons0_q;
            press1_d   = ~sh1_q & ~buttons1_q;
`endif
          end else begin
            pulse_d = pulse_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers. An asynchronous reset aborts any poll at once and also
  // drops the pending flag, so the first poll after release needs a fresh
  // request.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pulse_q    <= '0;
      tmr_q      <= '0;
      pending_q  <= 1'b0;
      sh0_q      <= 8'h00;
      sh1_q      <= 8'h00;
      buttons0_q <= 8'h00;
      buttons1_q <= 8'h00;
      valid_q    <= 1'b0;
`ifdef NES_PRESS_EVENT_EN
      press0_q   <= 8'h00;
      press1_q   <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulse_q    <= pulse_d;
      tmr_q      <= tmr_d;
      pending_q  <= pending_d;
      sh0_q      <= sh0_d;
      sh1_q      <= sh1_d;
      buttons0_q <= buttons0_d;
      buttons1_q <= buttons1_d;
      valid_q    <= valid_d;
`ifdef NES_PRESS_EVENT_EN
      press0_q   <= press0_d;
      press1_q   <= press1_d;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. latch and sclk are decoded from the state register, so they
  // fall in the same cycle that reset is asserted. They also come from
  // disjoint states, so they can never be high together.
  // -------------------------------------------------------------------------
  assign latch    = (state_q == ST_LATCH);
  assign sclk     = (state_q == ST_CAPTURE) && (cnt_q <= HALF_LAST);
  assign state    = state_q;
  assign busy     = (state_q != ST_IDLE);
  assign valid    = valid_q;
  assign buttons0 = buttons0_q;
  assign buttons1 = buttons1_q;
`ifdef NES_PRESS_EVENT_EN
  assign press0   = press0_q;
  assign press1   = press1_q;
`endif

endmodule

// File: tb/tb_nes_poll_scheduler.sv
// ---------------------------------------------------------------------------
// tb_nes_poll_scheduler
//
// Directed bench for nes_poll_scheduler. The DUT uses the default clock and
// latch timing (LATCH_CYC=144, HALF_CYC=72, 1153-cycle poll). POLL_HZ is
// raised to 10000 so the periodic timer wraps every 1200 cycles.
// Two behavioural controllers drive sdata0/sdata1 from pad0/pad1
// (bit7=A, 1 = pressed). A controller loads while latch is high, shifts on
// each rising sclk, and drives low for a pressed button.
// ---------------------------------------------------------------------------
module tb_nes_poll_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       sdata0 = 1'b1;
  logic       sdata1 = 1'b1;
  logic       latch;
  logic       sclk;
  logic [1:0] state;
  logic [7:0] buttons0;
  logic [7:0] buttons1;
  logic       valid;
  logic       busy;
`ifdef NES_PRESS_EVENT_EN
  logic [7:0] press0;
  logic [7:0] press1;
`endif

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  nes_poll_scheduler #(
    .CLK_FREQ(12000000),
    .POLL_HZ (10000),
    .LATCH_US(12)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .start   (start),
    .sdata0  (sdata0),
    .sdata1  (sdata1),
    .latch   (latch),
    .sclk    (sclk),
    .state   (state),
    .buttons0(buttons0),
    .buttons1(buttons1),
    .valid   (valid),
    .busy    (busy)
`ifdef NES_PRESS_EVENT_EN
    ,
    .press0  (press0),
    .press1  (press1)
`endif
  );

  // ---------------- controller models ----------------
  logic [7:0] pad0 = 8'h00;
  logic [7:0] pad1 = 8'h00;
  int         bit_idx = 8;
  logic       model_sclk_prev = 1'b0;

  always @(negedge clk) begin
    if (latch) begin
      bit_idx = 0;
    end else if (sclk && !model_sclk_prev) begin
      bit_idx = bit_idx + 1;
    end
    model_sclk_prev = sclk;
    sdata0 = (bit_idx < 8) ? ~pad0[7 - bit_idx] : 1'b1;
    sdata1 = (bit_idx < 8) ? ~pad1[7 - bit_idx] : 1'b1;
  end

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         latch_hi = 0;
  int         sclk_rise = 0;
  int         sclk_hi = 0;
  int         cap_lo = 0;
  int         overlap = 0;
  int         valid_cnt = 0;
  int         run_bad = 0;
  int         hi_run = 0;
  int         glitch = 0;
  int         start_cyc = 0;
  int         valid_cyc = 0;
  int         latch_entry_q[$];
  logic [7:0] b0_prev = 8'h00;
  logic [7:0] b1_prev = 8'h00;
  logic       mon_sclk_prev = 1'b0;
  logic [1:0] st_prev = 2'b00;

  always @(negedge clk) begin
    cyc++;
    if (latch) latch_hi++;
    if (latch && sclk) overlap++;
    if (state == 2'b11 && !sclk) cap_lo++;
    if (!reset) begin
      hi_run = 0;
    end else begin
      if (sclk) begin
        sclk_hi++;
        hi_run++;
      end
      if (sclk && !mon_sclk_prev) sclk_rise++;
      if (!sclk && mon_sclk_prev) begin
        if (hi_run != 72) run_bad++;
        hi_run = 0;
      end
      if (!valid && (buttons0 !== b0_prev || buttons1 !== b1_prev)) glitch++;
    end
    if (start) start_cyc = cyc;
    if (valid) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (state == 2'b01 && st_prev != 2'b01) latch_entry_q.push_back(cyc);
    b0_prev       = buttons0;
    b1_prev       = buttons1;
    mon_sclk_prev = sclk;
    st_prev       = state;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (valid) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_state: got %b expected 00", state); end
    checks++; if (latch !== 1'b0) begin errors++; $display("FAIL rst_latch: got %b expected 0", latch); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk: got %b expected 0", sclk); end
    checks++; if (buttons0 !== 8'h00) begin errors++; $display("FAIL rst_buttons0: got %h expected 00", buttons0); end
    checks++; if (buttons1 !== 8'h00) begin errors++; $display("FAIL rst_buttons1: got %h expected 00", buttons1); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    @(posedge clk); #1 reset = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (state !== 2'b00) begin errors++; $display("FAIL rst_idle_after_release: got %b expected 00", state); end
  endtask

  task automatic test_poll_a();
    int l0, r0, h0, c0, v0, rb0;
    bit seen;
    pad0 = 8'h80; pad1 = 8'h00;
    l0 = latch_hi; r0 = sclk_rise; h0 = sclk_hi; c0 = cap_lo; v0 = valid_cnt; rb0 = run_bad;
    pulse_start();
    @(negedge clk); #1;
    checks++; if (busy !== 1'b1 || state !== 2'b01) begin errors++; $display("FAIL a_busy_latch: got busy=%b state=%b expected 1/01", busy, state); end
    wait_valid(1300, seen);
    checks++; if (!seen) begin errors++; $display("FAIL a_valid_seen: got no valid expected valid within 1300 cycles"); end
    checks++; if (valid_cyc - start_cyc != 1153) begin errors++; $display("FAIL a_latency: got %0d expected 1153", valid_cyc - start_cyc); end
    checks++; if (buttons0 !== 8'h80) begin errors++; $display("FAIL a_buttons0: got %h expected 80", buttons0); end
    checks++; if (buttons1 !== 8'h00) begin errors++; $display("FAIL a_buttons1: got %h expected 00", buttons1); end
    checks++; if (state !== 2'b10) begin errors++; $display("FAIL a_done_state: got %b expected 10", state); end
    @(negedge clk); #1;
    checks++; if (valid !== 1'b0 || state !== 2'b00) begin errors++; $display("FAIL a_after_done: got valid=%b state=%b expected 0/00", valid, state); end
    checks++; if (valid_cnt - v0 != 1) begin errors++; $display("FAIL a_valid_width: got %0d expected 1", valid_cnt - v0); end
    checks++; if (latch_hi - l0 != 144) begin errors++; $display("FAIL a_latch_cycles: got %0d expected 144", latch_hi - l0); end
    checks++; if (sclk_rise - r0 != 7) begin errors++; $display("FAIL a_sclk_pulses: got %0d expected 7", sclk_rise - r0); end
    checks++; if (sclk_hi - h0 != 504 || cap_lo - c0 != 504) begin errors++; $display("FAIL a_sclk_phases: got hi=%0d lo=%0d expected 504/504", sclk_hi - h0, cap_lo - c0); end
    checks++; if (run_bad != rb0) begin errors++; $display("FAIL a_sclk_high_run: got %0d bad runs expected 0", run_bad - rb0); end
  endtask

  task automatic test_pattern();
    int l0, r0, h0, c0, rb0;
    bit seen;
    pad0 = 8'h10; pad1 = 8'h41;
    l0 = latch_hi; r0 = sclk_rise; h0 = sclk_hi; c0 = cap_lo; rb0 = run_bad;
    pulse_start();
    wait_valid(1300, seen);
    checks++; if (!seen) begin errors++; $display("FAIL pat_valid_seen: got no valid expected valid within 1300 cycles"); end
    checks++; if (buttons0 !== 8'h10) begin errors++; $display("FAIL pat_buttons0: got %h expected 10", buttons0); end
    checks++; if (buttons1 !== 8'h41) begin errors++; $display("FAIL pat_buttons1: got %h expected 41", buttons1); end
    checks++; if (latch_hi - l0 != 144) begin errors++; $display("FAIL pat_latch_cycles: got %0d expected 144", latch_hi - l0); end
    checks++; if (sclk_rise - r0 != 7) begin errors++; $display("FAIL pat_sclk_pulses: got %0d expected 7", sclk_rise - r0); end
    checks++; if (sclk_hi - h0 != 504 || cap_lo - c0 != 504 || run_bad != rb0) begin errors++; $display("FAIL pat_sclk_shape: got hi=%0d lo=%0d bad=%0d expected 504/504/0", sclk_hi - h0, cap_lo - c0, run_bad - rb0); end
    checks++; if (overlap != 0) begin errors++; $display("FAIL pat_overlap: got %0d expected 0", overlap); end
  endtask

  task automatic test_hold_update();
    bit seen;
    pad0 = 8'hFF; pad1 = 8'h00;
    pulse_start();
    wait_valid(1300, seen);
    checks++; if (!seen || buttons0 !== 8'hFF || buttons1 !== 8'h00) begin errors++; $display("FAIL hold_first: got seen=%b %h/%h expected 1 ff/00", seen, buttons0, buttons1); end
    pad0 = 8'h00; pad1 = 8'hFF;
    repeat (200) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (buttons0 !== 8'hFF || buttons1 !== 8'h00) begin errors++; $display("FAIL hold_idle: got %h/%h expected ff/00", buttons0, buttons1); end
    pulse_start();
    repeat (600) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (buttons0 !== 8'hFF || buttons1 !== 8'h00) begin errors++; $display("FAIL hold_mid_poll: got %h/%h expected ff/00", buttons0, buttons1); end
    wait_valid(1000, seen);
    checks++; if (!seen || buttons0 !== 8'h00 || buttons1 !== 8'hFF) begin errors++; $display("FAIL hold_second: got seen=%b %h/%h expected 1 00/ff", seen, buttons0, buttons1); end
    checks++; if (glitch != 0) begin errors++; $display("FAIL hold_no_partial: got %0d changes outside valid expected 0", glitch); end
  endtask

  task automatic test_reset_mid_poll();
    int v0;
    bit found, seen;
    pad0 = 8'h24; pad1 = 8'h18;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk); #1;
      if (state == 2'b11 && sclk) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL rmid_reach_capture: got no capture expected sclk high in capture"); end
    v0 = valid_cnt;
    reset = 1'b0;
    #1;
    checks++; if (latch !== 1'b0 || sclk !== 1'b0) begin errors++; $display("FAIL rmid_lines: got latch=%b sclk=%b expected 0/0", latch, sclk); end
    checks++; if (state !== 2'b00 || busy !== 1'b0) begin errors++; $display("FAIL rmid_state: got %b busy=%b expected 00/0", state, busy); end
    checks++; if (buttons0 !== 8'h00 || buttons1 !== 8'h00) begin errors++; $display("FAIL rmid_buttons: got %h/%h expected 00/00", buttons0, buttons1); end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (50) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (state !== 2'b00 || valid_cnt != v0) begin errors++; $display("FAIL rmid_no_resume: got state=%b valids=%0d expected 00/0", state, valid_cnt - v0); end
    pulse_start();
    wait_valid(1300, seen);
    checks++; if (!seen || valid_cyc - start_cyc != 1153) begin errors++; $display("FAIL rmid_repoll_latency: got seen=%b lat=%0d expected 1/1153", seen, valid_cyc - start_cyc); end
    checks++; if (buttons0 !== 8'h24 || buttons1 !== 8'h18) begin errors++; $display("FAIL rmid_repoll_buttons: got %h/%h expected 24/18", buttons0, buttons1); end
  endtask

  task automatic test_periodic();
    int v0, d1, d2;
    bit seen;
    pad0 = 8'h03; pad1 = 8'h0C;
    latch_entry_q.delete();
    v0 = valid_cnt;
    // Start lands in the same cycle as the first tick: one poll, no pending.
    @(posedge clk); #1 enable = 1'b1;
    repeat (1199) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 3000 && latch_entry_q.size() < 2; i++) begin
      @(negedge clk); #1;
    end
    checks++; if (latch_entry_q.size() != 2) begin errors++; $display("FAIL per_two_ticks: got %0d polls expected 2", latch_entry_q.size()); end
    d1 = (latch_entry_q.size() >= 2) ? latch_entry_q[1] - latch_entry_q[0] : -1;
    checks++; if (d1 != 1200) begin errors++; $display("FAIL per_period: got %0d expected 1200", d1); end
    // Two starts during a poll fold into one back-to-back poll.
    repeat (500) @(posedge clk);
    pulse_start();
    repeat (100) @(posedge clk);
    pulse_start();
    for (int i = 0; i < 1000 && latch_entry_q.size() < 3; i++) begin
      @(negedge clk); #1;
    end
    enable = 1'b0;
    wait_valid(1300, seen);
    checks++; if (!seen || buttons0 !== 8'h03 || buttons1 !== 8'h0C) begin errors++; $display("FAIL per_extra_poll: got seen=%b %h/%h expected 1 03/0c", seen, buttons0, buttons1); end
    repeat (1500) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (latch_entry_q.size() != 3) begin errors++; $display("FAIL per_poll_count: got %0d expected 3", latch_entry_q.size()); end
    d2 = (latch_entry_q.size() >= 3) ? latch_entry_q[2] - latch_entry_q[1] : -1;
    checks++; if (d2 != 1154) begin errors++; $display("FAIL per_back_to_back: got %0d expected 1154", d2); end
    checks++; if (valid_cnt - v0 != 3) begin errors++; $display("FAIL per_valid_count: got %0d expected 3", valid_cnt - v0); end
  endtask

`ifdef NES_PRESS_EVENT_EN
  task automatic test_press_event();
    bit seen;
    pad0 = 8'h80; pad1 = 8'h00;
    @(negedge clk); #1;
    checks++; if (press0 !== 8'h00) begin errors++; $display("FAIL press_idle: got %h expected 00", press0); end
    pulse_start();
    wait_valid(1300, seen);
    checks++; if (!seen || press0 !== 8'h80 || press1 !== 8'h00) begin errors++; $display("FAIL press_first: got seen=%b %h/%h expected 1 80/00", seen, press0, press1); end
    @(negedge clk); #1;
    checks++; if (press0 !== 8'h00) begin errors++; $display("FAIL press_after_valid: got %h expected 00", press0); end
    pulse_start();
    wait_valid(1300, seen);
    checks++; if (!seen || press0 !== 8'h00 || buttons0 !== 8'h80) begin errors++; $display("FAIL press_second: got seen=%b press0=%h buttons0=%h expected 1 00 80", seen, press0, buttons0); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_poll_a();
    test_pattern();
    test_hold_update();
    test_reset_mid_poll();
    test_periodic();
`ifdef NES_PRESS_EVENT_EN
    test_press_event();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
